serial_adder: RTL and testbench
===============================

# serial_adder

Multi-cycle, parametrised two's-complement adder/subtractor built from a slice of ripple-connected full-adder cells plus a registered carry. Operands are captured on a start request and processed BITS_PER_CYCLE bits per clock, LSB slice first. It is the area-reduced arithmetic unit for datapaths that can accept multi-cycle latency. With WIDTH=1 it degenerates to one registered full adder, which makes it a drop-in check against the existing single-bit cell.

## Interface
- WIDTH, 8, operand and result width in bits; must be ≥ 1.
- BITS_PER_CYCLE, 1, full-adder cells in the slice; must be ≥ 1 and divide WIDTH exactly.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous assert, active-low; one clock domain.
- start  input  1  operation request; sampled only while busy=0.
- sub  input  1  0 = a+b+cin; 1 = a−b−cin (a + ~b + ~cin).
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- cin  input  1  carry-in (borrow-in when sub=1); sampled with start.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse; result outputs are valid from this cycle.
- sum  output  WIDTH  result; holds its value until the next completion.
- cout  output  1  carry-out of the MSB (for sub, 1 = no borrow).
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- S = WIDTH/BITS_PER_CYCLE slices. Counter width is clog2(S+1).
- FSM states: IDLE and RUN.
- IDLE, start=1 at an edge:
  - latch a into the A shift register;
  - latch b XOR {WIDTH{sub}} into the B shift register;
  - carry register ← cin XOR sub;
  - slice counter ← 0; busy ← 1; go to RUN.
- Each RUN edge:
  - ripple the low BITS_PER_CYCLE bits of A and B plus the carry through the cells;
  - shift the slice result into the accumulating result register from the top;
  - shift A and B right by BITS_PER_CYCLE;
  - carry ← carry out of the top cell of the slice;
  - on the last slice, also capture the carry into the top cell of the slice (the MSB carry-in) for ovf.
- After slice S−1:
  - sum ← result register; cout ← final carry; ovf ← MSB carry-in XOR final carry;
  - done ← 1; busy ← 0; go to IDLE.
- start while busy=1 is ignored. Operands and sub are not re-sampled mid-operation.
- sum, cout and ovf are not cleared on start. They change only at completion, so the previous result stays readable while busy.
- done deasserts on the next edge unless that edge completes another operation; it cannot, since S ≥ 1.

## Timing
- Reset values (asynchronous, while rst_n=0): busy=0, done=0, sum=0, cout=0, ovf=0, FSM=IDLE, counter=0, carry=0.
- Reset mid-operation aborts the operation: no done pulse, and sum keeps its reset value 0.
- Start accepted at edge E0: busy=1 after E0.
- Slices are processed at edges E1..ES.
- After ES: busy=0, done=1, result valid.
- After E(S+1): done=0.
- Latency from the accepting edge to done is S cycles. Back-to-back throughput is one operation per S+1 cycles.
- A start held high during the done cycle (IDLE) is accepted at that edge, so continuous start gives an operation every S+1 cycles.
- start, a, b, cin and sub must be stable only around the accepting edge.
- Combinational depth is BITS_PER_CYCLE full-adder carry stages.

## Test plan
- WIDTH=1, BITS_PER_CYCLE=1, sub=0: drive all 8 {a,b,cin} combinations.
  - Required: sum/cout match the full-adder table: 000→0/0, 001→1/0, 010→1/0, 100→1/0, 011→0/1, 110→0/1, 101→0/1, 111→1/1.
  - Required: done exactly 1 cycle after each accepting edge.
- WIDTH=8, BITS_PER_CYCLE=1, add:
  - 0xFF+0x01, cin=0 → sum=0x00, cout=1, ovf=0; done 8 edges after the start edge.
  - 0x7F+0x01 → sum=0x80, cout=0, ovf=1.
- WIDTH=8, sub=1:
  - 0x05−0x07, cin=0 → sum=0xFE, cout=0, ovf=0.
  - 0x80−0x01 → sum=0x7F, cout=1, ovf=1.
  - 0x10−0x00, cin=1 → sum=0x0F, cout=1.
- WIDTH=8, BITS_PER_CYCLE=4: 0x3C+0xC4 → sum=0x00, cout=1, ovf=0; done 2 edges after start; busy high for exactly 2 cycles.
- Start pulsed again 3 cycles into a WIDTH=8, BITS_PER_CYCLE=1 operation with different operands.
  - Required: ignored; first result returned unchanged; no extra done pulse.
  - Then hold start high: operations complete every 9 cycles.
- Assert rst_n=0 at slice 4 of an operation.
  - Required: immediately busy=0, done=0, sum=0, cout=0, ovf=0; no done pulse afterwards.
  - A new start after reset release completes normally.

Source files
------------

// File: rtl/serial_adder_if.sv
// rtl/serial_adder_if.sv - operation request/result bundle for serial_adder
//
// Purpose: groups the operand request and result signals of serial_adder.
// Ports (signals):
//   start, sub, cin, a[WIDTH], b[WIDTH]   request side, driven by the master
//   busy, done, cout, ovf, sum[WIDTH]     result side, driven by the adder
// Modports: master (requester), slave (the adder).
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic             cin;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             cout;
  logic             ovf;
  logic [WIDTH-1:0] sum;

  modport master (
    output start, sub, cin, a, b,
    input  busy, done, cout, ovf, sum
  );

  modport slave (
    input  start, sub, cin, a, b,
    output busy, done, cout, ovf, sum
  );
endinterface

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - multi-cycle two's-complement adder/subtractor
//
// Purpose: adds or subtracts two WIDTH-bit operands BITS_PER_CYCLE bits per
// clock through a slice of ripple-connected full-adder cells and a registered
// carry, LSB slice first.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    serial_adder_if.slave: start/sub/cin/a/b in, busy/done/sum/cout/ovf out
module serial_adder #(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_adder_if.slave  bus
);

  localparam int BPC = BITS_PER_CYCLE;
  localparam int S   = WIDTH / BPC;
  localparam int CW  = $clog2(S + 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_next;
  logic [WIDTH-1:0] sum_q;
  logic             carry;
  logic             done_q;
  logic             cout_q;
  logic             ovf_q;
  logic [CW-1:0]    cnt;

  logic             load;
  logic             step;
  logic             last;

  logic [BPC-1:0]   slice_sum;
  logic [BPC:0]     ch;

  // Ripple the registered carry through the slice; ch[k] is the carry into cell k.
  always_comb begin
    ch        = '0;
    slice_sum = '0;
    ch[0]     = carry;
    for (int k = 0; k < BPC; k++) begin
      slice_sum[k] = a_sr[k] ^ b_sr[k] ^ ch[k];
      ch[k+1]      = (a_sr[k] & b_sr[k]) | (ch[k] & (a_sr[k] ^ b_sr[k]));
    end
  end

  // Slice results enter from the top so after S steps the LSB slice sits at bit 0.
  generate
    if (BPC == WIDTH) begin : g_full_slice
      assign res_next = slice_sum;
    end else begin : g_part_slice
      assign res_next = {slice_sum, res[WIDTH-1:BPC]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    last       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt == CW'(S - 1)) begin
          last       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res    <= '0;
      sum_q  <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      done_q <= 1'b0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      done_q <= last;
      if (load) begin
        // Subtraction is a + ~b + ~cin: invert B and the carry-in once at capture.
        a_sr  <= bus.a;
        b_sr  <= bus.b ^ {WIDTH{bus.sub}};
        carry <= bus.cin ^ bus.sub;
        cnt   <= '0;
      end else if (step) begin
        a_sr  <= a_sr >> BPC;
        b_sr  <= b_sr >> BPC;
        carry <= ch[BPC];
        res   <= res_next;
        cnt   <= cnt + CW'(1);
        if (last) begin
          // On the last slice ch[BPC-1] is the carry into the MSB cell.
          sum_q  <= res_next;
          cout_q <= ch[BPC];
          ovf_q  <= ch[BPC-1] ^ ch[BPC];
        end
      end
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - testbench for serial_adder in three configurations
//
// Purpose: drives a 1-bit, an 8-bit/1-bit-per-cycle and an 8-bit/4-bit-per-cycle
// instance with directed vectors and checks every cycle against an
// arithmetic reference model, plus hand-computed literal results.
// Ports: none (top-level bench).
module tb_serial_adder;

  localparam int N = 3;
  localparam int W_OF[N] = '{1, 8, 8};
  localparam int S_OF[N] = '{1, 8, 2};

  logic clk = 1'b0;
  logic rst_n;

  logic       st[N];
  logic       sb[N];
  logic       ci[N];
  logic [7:0] av[N];
  logic [7:0] bv[N];

  logic       bz[N];
  logic       dn[N];
  logic       co[N];
  logic       ov[N];
  logic [7:0] sm[N];

  int n_checks;
  int n_err;
  logic chk_en;

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(1)) if0 ();
  serial_adder_if #(.WIDTH(8)) if1 ();
  serial_adder_if #(.WIDTH(8)) if2 ();

  serial_adder #(.WIDTH(1), .BITS_PER_CYCLE(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(4)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  assign if0.start = st[0];
  assign if0.sub   = sb[0];
  assign if0.cin   = ci[0];
  assign if0.a     = av[0][0:0];
  assign if0.b     = bv[0][0:0];
  assign bz[0] = if0.busy;
  assign dn[0] = if0.done;
  assign co[0] = if0.cout;
  assign ov[0] = if0.ovf;
  assign sm[0] = {7'b0, if0.sum};

  assign if1.start = st[1];
  assign if1.sub   = sb[1];
  assign if1.cin   = ci[1];
  assign if1.a     = av[1];
  assign if1.b     = bv[1];
  assign bz[1] = if1.busy;
  assign dn[1] = if1.done;
  assign co[1] = if1.cout;
  assign ov[1] = if1.ovf;
  assign sm[1] = if1.sum;

  assign if2.start = st[2];
  assign if2.sub   = sb[2];
  assign if2.cin   = ci[2];
  assign if2.a     = av[2];
  assign if2.b     = bv[2];
  assign bz[2] = if2.busy;
  assign dn[2] = if2.done;
  assign co[2] = if2.cout;
  assign ov[2] = if2.ovf;
  assign sm[2] = if2.sum;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result from plain integer arithmetic: returns {ovf, cout, sum}.
  function automatic logic [9:0] calc(input int w, input logic [7:0] a, input logic [7:0] b,
                                      input logic c, input logic s);
    longint mask, au, bu, u, as_, bs_, r, half;
    logic [7:0] rs;
    logic rc, ro;
    mask = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    au = longint'(a) & mask;
    bu = longint'(b) & mask;
    u  = s ? (au - bu - longint'(c)) : (au + bu + longint'(c));
    rs = 8'(u & mask);
    rc = s ? (u >= 0) : (u > mask);
    as_ = (au >= half) ? au - (mask + 1) : au;
    bs_ = (bu >= half) ? bu - (mask + 1) : bu;
    r  = s ? (as_ - bs_ - longint'(c)) : (as_ + bs_ + longint'(c));
    ro = (r < -half) || (r > half - 1);
    return {ro, rc, rs};
  endfunction

  logic       m_busy[N];
  logic       m_done[N];
  logic       m_cout[N];
  logic       m_ovf[N];
  logic [7:0] m_sum[N];
  int         m_rem[N];
  logic [9:0] m_pend[N];

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < N; i++) begin
      if (!rst_n) begin
        m_busy[i] <= 1'b0;
        m_done[i] <= 1'b0;
        m_cout[i] <= 1'b0;
        m_ovf[i]  <= 1'b0;
        m_sum[i]  <= 8'h00;
        m_rem[i]  <= 0;
        m_pend[i] <= 10'h000;
      end else begin
        m_done[i] <= 1'b0;
        if (!m_busy[i]) begin
          if (st[i]) begin
            m_busy[i] <= 1'b1;
            m_rem[i]  <= S_OF[i];
            m_pend[i] <= calc(W_OF[i], av[i], bv[i], ci[i], sb[i]);
          end
        end else if (m_rem[i] == 1) begin
          m_busy[i] <= 1'b0;
          m_done[i] <= 1'b1;
          m_sum[i]  <= m_pend[i][7:0];
          m_cout[i] <= m_pend[i][8];
          m_ovf[i]  <= m_pend[i][9];
        end else begin
          m_rem[i] <= m_rem[i] - 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < N; i++) begin
        chk($sformatf("busy[%0d]", i), 32'(bz[i]), 32'(m_busy[i]));
        chk($sformatf("done[%0d]", i), 32'(dn[i]), 32'(m_done[i]));
        chk($sformatf("sum[%0d]", i),  32'(sm[i]), 32'(m_sum[i]));
        chk($sformatf("cout[%0d]", i), 32'(co[i]), 32'(m_cout[i]));
        chk($sformatf("ovf[%0d]", i),  32'(ov[i]), 32'(m_ovf[i]));
      end
    end
  end

  task automatic run_op(input int i, input logic [7:0] a, input logic [7:0] b, input logic c,
                        input logic s, input logic [7:0] es, input logic ec, input logic eo,
                        input logic check_ovf, input int lat, input string name);
    int cyc;
    int nb;
    @(negedge clk);
    av[i] = a;
    bv[i] = b;
    ci[i] = c;
    sb[i] = s;
    st[i] = 1'b1;
    @(negedge clk);
    st[i] = 1'b0;
    chk({name, "_busy_after_accept"}, 32'(bz[i]), 32'd1);
    cyc = 0;
    nb  = 1;
    while (!dn[i] && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (bz[i]) nb++;
    end
    chk({name, "_latency"}, cyc, lat);
    chk({name, "_busy_cycles"}, nb, lat);
    chk({name, "_sum"}, 32'(sm[i]), 32'(es));
    chk({name, "_cout"}, 32'(co[i]), 32'(ec));
    if (check_ovf) chk({name, "_ovf"}, 32'(ov[i]), 32'(eo));
  endtask

  logic [7:0] tab_s;
  logic [7:0] tab_c;
  logic [2:0] jv;
  int ndone;
  int t;
  int last_t;

  initial begin
    for (int i = 0; i < N; i++) begin
      st[i] = 1'b0;
      sb[i] = 1'b0;
      ci[i] = 1'b0;
      av[i] = 8'h00;
      bv[i] = 8'h00;
    end
    n_checks = 0;
    n_err    = 0;
    chk_en   = 1'b0;
    rst_n    = 1'b0;

    repeat (2) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("reset_busy[%0d]", i), 32'(bz[i]), 32'd0);
      chk($sformatf("reset_done[%0d]", i), 32'(dn[i]), 32'd0);
      chk($sformatf("reset_sum[%0d]", i),  32'(sm[i]), 32'd0);
      chk($sformatf("reset_cout[%0d]", i), 32'(co[i]), 32'd0);
      chk($sformatf("reset_ovf[%0d]", i),  32'(ov[i]), 32'd0);
    end
    #2 rst_n = 1'b1;
    chk_en = 1'b1;

    // Full-adder truth table indexed by {a,b,cin}.
    tab_s = 8'b1001_0110;
    tab_c = 8'b1110_1000;
    for (int j = 0; j < 8; j++) begin
      jv = 3'(j);
      run_op(0, {7'b0, jv[2]}, {7'b0, jv[1]}, jv[0], 1'b0, {7'b0, tab_s[j]}, tab_c[j], 1'b0,
             1'b0, 1, $sformatf("fa_%0d", j));
    end

    run_op(1, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8, "add_ff_01");
    run_op(1, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b1, 8, "add_7f_01");
    run_op(1, 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b1, 8, "sub_05_07");
    run_op(1, 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b1, 8, "sub_80_01");
    run_op(1, 8'h10, 8'h00, 1'b1, 1'b1, 8'h0F, 1'b1, 1'b0, 1'b1, 8, "sub_10_00_c1");
    run_op(2, 8'h3C, 8'hC4, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 2, "bpc4_3c_c4");

    // Start pulsed mid-operation must be ignored.
    @(negedge clk);
    av[1] = 8'h12; bv[1] = 8'h34; ci[1] = 1'b0; sb[1] = 1'b0; st[1] = 1'b1;
    @(negedge clk);
    st[1] = 1'b0;
    repeat (2) @(negedge clk);
    av[1] = 8'hAA; bv[1] = 8'h55; ci[1] = 1'b1; sb[1] = 1'b1; st[1] = 1'b1;
    @(negedge clk);
    st[1] = 1'b0; sb[1] = 1'b0; ci[1] = 1'b0;
    t = 0;
    while (!dn[1] && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("ignore_sum", 32'(sm[1]), 32'h46);
    chk("ignore_cout", 32'(co[1]), 32'd0);
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (dn[1]) ndone++;
    end
    chk("ignore_no_extra_done", ndone, 0);

    // Continuous start: one completion every S+1 cycles.
    @(negedge clk);
    av[1] = 8'h01; bv[1] = 8'h02; st[1] = 1'b1;
    ndone = 0;
    t = 0;
    last_t = 0;
    while (ndone < 3 && t < 100) begin
      @(negedge clk);
      t++;
      if (dn[1]) begin
        if (ndone > 0) chk("hold_interval", t - last_t, 9);
        last_t = t;
        ndone++;
      end
    end
    st[1] = 1'b0;
    chk("hold_count", ndone, 3);
    chk("hold_sum", 32'(sm[1]), 32'h03);
    repeat (10) @(negedge clk);

    // Reset at slice 4 aborts the operation.
    av[1] = 8'h22; bv[1] = 8'h11; st[1] = 1'b1;
    @(negedge clk);
    st[1] = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", 32'(bz[1]), 32'd0);
    chk("rst_done", 32'(dn[1]), 32'd0);
    chk("rst_sum",  32'(sm[1]), 32'd0);
    chk("rst_cout", 32'(co[1]), 32'd0);
    chk("rst_ovf",  32'(ov[1]), 32'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (dn[1]) ndone++;
    end
    chk("rst_no_done", ndone, 0);
    chk("rst_sum_held", 32'(sm[1]), 32'd0);
    run_op(1, 8'h22, 8'h11, 1'b0, 1'b0, 8'h33, 1'b0, 1'b0, 1'b1, 8, "after_reset");

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
